// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note events onto VOICES synthesis voices,
// tracking per-voice state and age for retrigger, stealing and sustain-pedal handling.
module voice_allocator #(
    parameter int unsigned VOICES         = 4,
    parameter int unsigned NOTE_WIDTH     = 7,
    parameter int unsigned VELOCITY_WIDTH = 7
) (
    input  logic                               clock_50_000_000,
    input  logic                               reset,
    input  logic                               event_valid,
    output logic                               event_ready,
    input  logic                               event_is_on,
    input  logic [NOTE_WIDTH-1:0]              event_note,
    input  logic [VELOCITY_WIDTH-1:0]          event_velocity,
    input  logic                               sustain_pedal,
    input  logic [VOICES-1:0]                  envelope_end,
    output logic [VOICES-1:0]                  voice_note_on,
    output logic [VOICES-1:0]                  voice_note_off,
    output logic [VOICES*NOTE_WIDTH-1:0]       voice_note,
    output logic [VOICES*VELOCITY_WIDTH-1:0]   voice_velocity,
    output logic [VOICES-1:0]                  voice_active
);

    localparam int unsigned RANK_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int unsigned IDX_W  = RANK_W;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_SUSTAINED = 2'd2,
        ST_RELEASING = 2'd3
    } voice_state_e;

    voice_state_e               r_state    [VOICES];
    voice_state_e               w_state_nxt[VOICES];
    logic [RANK_W-1:0]          r_rank     [VOICES];
    logic [RANK_W-1:0]          w_rank_nxt [VOICES];
    logic [NOTE_WIDTH-1:0]      r_note     [VOICES];
    logic [NOTE_WIDTH-1:0]      w_note_nxt [VOICES];
    logic [VELOCITY_WIDTH-1:0]  r_vel      [VOICES];
    logic [VELOCITY_WIDTH-1:0]  w_vel_nxt  [VOICES];

    logic [VOICES-1:0]          r_on;
    logic [VOICES-1:0]          r_off;
    logic [VOICES-1:0]          r_active;
    logic [VOICES-1:0]          w_on_nxt;
    logic [VOICES-1:0]          w_off_nxt;
    logic [VOICES-1:0]          w_active_nxt;
    logic                       r_pedal;
    logic                       r_ready;

    logic                       w_accept;
    logic                       w_is_on;
    logic                       w_is_off;
    logic                       w_pedal_fall;

    logic                       w_retrig_hit;
    logic [IDX_W-1:0]           w_retrig_idx;
    logic                       w_free_hit;
    logic [IDX_W-1:0]           w_free_idx;
    logic                       w_rel_hit;
    logic [IDX_W-1:0]           w_rel_idx;
    logic [RANK_W-1:0]          w_rel_rank;
    logic                       w_sus_hit;
    logic [IDX_W-1:0]           w_sus_idx;
    logic [RANK_W-1:0]          w_sus_rank;
    logic                       w_held_hit;
    logic [IDX_W-1:0]           w_held_idx;
    logic [RANK_W-1:0]          w_held_rank;
    logic                       w_off_hit;
    logic [IDX_W-1:0]           w_off_idx;
    logic [IDX_W-1:0]           w_target_idx;
    logic [RANK_W-1:0]          w_target_rank;

    // Event decode and candidate search, all on pre-cycle state.
    always_comb begin
        w_accept     = event_valid && r_ready;
        w_is_on      = w_accept && event_is_on && (event_velocity != '0);
        w_is_off     = w_accept && !w_is_on;
        w_pedal_fall = r_pedal && !sustain_pedal;

        w_retrig_hit = 1'b0;
        w_retrig_idx = '0;
        w_free_hit   = 1'b0;
        w_free_idx   = '0;
        w_off_hit    = 1'b0;
        w_off_idx    = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = int'(VOICES) - 1; i >= 0; i--) begin
            if (r_state[i] != ST_FREE && r_note[i] == event_note) begin
                w_retrig_hit = 1'b1;
                w_retrig_idx = IDX_W'(i);
            end
            if (r_state[i] == ST_FREE) begin
                w_free_hit = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == ST_HELD && r_note[i] == event_note) begin
                w_off_hit = 1'b1;
                w_off_idx = IDX_W'(i);
            end
        end

        w_rel_hit   = 1'b0;
        w_rel_idx   = '0;
        w_rel_rank  = '0;
        w_sus_hit   = 1'b0;
        w_sus_idx   = '0;
        w_sus_rank  = '0;
        w_held_hit  = 1'b0;
        w_held_idx  = '0;
        w_held_rank = '0;
        // Oldest voice per state; ranks are unique so ties cannot occur.
        for (int i = 0; i < int'(VOICES); i++) begin
            if (r_state[i] == ST_RELEASING && (!w_rel_hit || r_rank[i] > w_rel_rank)) begin
                w_rel_hit  = 1'b1;
                w_rel_idx  = IDX_W'(i);
                w_rel_rank = r_rank[i];
            end
            if (r_state[i] == ST_SUSTAINED && (!w_sus_hit || r_rank[i] > w_sus_rank)) begin
                w_sus_hit  = 1'b1;
                w_sus_idx  = IDX_W'(i);
                w_sus_rank = r_rank[i];
            end
            if (r_state[i] == ST_HELD && (!w_held_hit || r_rank[i] > w_held_rank)) begin
                w_held_hit  = 1'b1;
                w_held_idx  = IDX_W'(i);
                w_held_rank = r_rank[i];
            end
        end

        if (w_retrig_hit) begin
            w_target_idx = w_retrig_idx;
        end else if (w_free_hit) begin
            w_target_idx = w_free_idx;
        end else if (w_rel_hit) begin
            w_target_idx = w_rel_idx;
        end else if (w_sus_hit) begin
            w_target_idx = w_sus_idx;
        end else begin
            w_target_idx = w_held_idx;
        end
        w_target_rank = r_rank[w_target_idx];
    end

    // Next-state: pedal release and envelope ends first, then the note event overrides.
    always_comb begin
        for (int i = 0; i < int'(VOICES); i++) begin
            w_state_nxt[i] = r_state[i];
            w_rank_nxt[i]  = r_rank[i];
            w_note_nxt[i]  = r_note[i];
            w_vel_nxt[i]   = r_vel[i];
        end
        w_on_nxt     = '0;
        w_off_nxt    = '0;
        w_active_nxt = '0;

        for (int i = 0; i < int'(VOICES); i++) begin
            if (w_pedal_fall && r_state[i] == ST_SUSTAINED) begin
                w_state_nxt[i] = ST_RELEASING;
                w_off_nxt[i]   = 1'b1;
            end
            if (envelope_end[i] && r_state[i] == ST_RELEASING) begin
                w_state_nxt[i] = ST_FREE;
            end
        end

        for (int i = 0; i < int'(VOICES); i++) begin
            if (w_is_off && w_off_hit && IDX_W'(i) == w_off_idx) begin
                if (sustain_pedal) begin
                    w_state_nxt[i] = ST_SUSTAINED;
                end else begin
                    w_state_nxt[i] = ST_RELEASING;
                    w_off_nxt[i]   = 1'b1;
                end
            end
            if (w_is_on) begin
                if (IDX_W'(i) == w_target_idx) begin
                    w_state_nxt[i] = ST_HELD;
                    w_rank_nxt[i]  = '0;
                    w_note_nxt[i]  = event_note;
                    w_vel_nxt[i]   = event_velocity;
                    w_on_nxt[i]    = 1'b1;
                    w_off_nxt[i]   = 1'b0;
                end else if (r_rank[i] < w_target_rank) begin
                    w_rank_nxt[i] = r_rank[i] + RANK_W'(1);
                end
            end
        end

        for (int i = 0; i < int'(VOICES); i++) begin
            w_active_nxt[i] = (w_state_nxt[i] != ST_FREE);
        end
    end

    // State register.
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            for (int i = 0; i < int'(VOICES); i++) begin
                r_state[i] <= ST_FREE;
                r_rank[i]  <= RANK_W'(i);
                r_note[i]  <= '0;
                r_vel[i]   <= '0;
            end
            r_on     <= '0;
            r_off    <= '0;
            r_active <= '0;
            r_pedal  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(VOICES); i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rank[i]  <= w_rank_nxt[i];
                r_note[i]  <= w_note_nxt[i];
                r_vel[i]   <= w_vel_nxt[i];
            end
            r_on     <= w_on_nxt;
            r_off    <= w_off_nxt;
            r_active <= w_active_nxt;
            r_pedal  <= sustain_pedal;
            r_ready  <= 1'b1;
        end
    end

    for (genvar g = 0; g < int'(VOICES); g++) begin : g_pack
        assign voice_note[g*NOTE_WIDTH +: NOTE_WIDTH]             = r_note[g];
        assign voice_velocity[g*VELOCITY_WIDTH +: VELOCITY_WIDTH] = r_vel[g];
    end

    assign event_ready    = r_ready;
    assign voice_note_on  = r_on;
    assign voice_note_off = r_off;
    assign voice_active   = r_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: each driven cycle queues its expected
// registered outputs, which a monitor compares one edge later.
module tb_voice_allocator;

    localparam int unsigned VOICES = 4;
    localparam int unsigned NW     = 7;
    localparam int unsigned VW     = 7;

    logic                    clk;
    logic                    reset;
    logic                    event_valid;
    logic                    event_ready;
    logic                    event_is_on;
    logic [NW-1:0]           event_note;
    logic [VW-1:0]           event_velocity;
    logic                    sustain_pedal;
    logic [VOICES-1:0]       envelope_end;
    logic [VOICES-1:0]       voice_note_on;
    logic [VOICES-1:0]       voice_note_off;
    logic [VOICES*NW-1:0]    voice_note;
    logic [VOICES*VW-1:0]    voice_velocity;
    logic [VOICES-1:0]       voice_active;

    voice_allocator #(.VOICES(VOICES), .NOTE_WIDTH(NW), .VELOCITY_WIDTH(VW)) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .event_valid      (event_valid),
        .event_ready      (event_ready),
        .event_is_on      (event_is_on),
        .event_note       (event_note),
        .event_velocity   (event_velocity),
        .sustain_pedal    (sustain_pedal),
        .envelope_end     (envelope_end),
        .voice_note_on    (voice_note_on),
        .voice_note_off   (voice_note_off),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_active     (voice_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic              ready;
        logic [VOICES-1:0] on;
        logic [VOICES-1:0] off;
        logic [VOICES-1:0] act;
        int                vi;
        logic [NW-1:0]     note;
        logic [VW-1:0]     vel;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show after the edge.
    task automatic apply(input string tag, input logic rst, input logic vld, input logic on,
                         input logic [NW-1:0] nt, input logic [VW-1:0] vl, input logic ped,
                         input logic [VOICES-1:0] ee, input logic [VOICES-1:0] x_on,
                         input logic [VOICES-1:0] x_off, input logic [VOICES-1:0] x_act,
                         input int vi, input logic [NW-1:0] xn, input logic [VW-1:0] xv);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        event_valid    = vld;
        event_is_on    = on;
        event_note     = nt;
        event_velocity = vl;
        sustain_pedal  = ped;
        envelope_end   = ee;
        e.tag   = tag;
        e.ready = !rst;
        e.on    = x_on;
        e.off   = x_off;
        e.act   = x_act;
        e.vi    = vi;
        e.note  = xn;
        e.vel   = xv;
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, ".ready"}, 32'(event_ready), 32'(e.ready));
            check({e.tag, ".on"}, 32'(voice_note_on), 32'(e.on));
            check({e.tag, ".off"}, 32'(voice_note_off), 32'(e.off));
            check({e.tag, ".active"}, 32'(voice_active), 32'(e.act));
            if (e.vi >= 0) begin
                check({e.tag, ".note"}, 32'(voice_note[e.vi*NW +: NW]), 32'(e.note));
                check({e.tag, ".vel"}, 32'(voice_velocity[e.vi*VW +: VW]), 32'(e.vel));
            end
        end
    end

    initial begin
        reset = 1'b1; event_valid = 1'b0; event_is_on = 1'b0; event_note = '0;
        event_velocity = '0; sustain_pedal = 1'b0; envelope_end = '0;

        //      tag       rst vld on  note vel ped ee       x_on     x_off    x_act    vi  xn  xv
        apply("rst0",    1, 0, 0,  0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,  0,  0);
        apply("rst1",    1, 1, 1, 60, 100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3,  0,  0);
        apply("idle0",   0, 0, 0,  0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, 0,  0);
        // single note on / off / double off / envelope end
        apply("on60",    0, 1, 1, 60, 100, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 60, 100);
        apply("hold",    0, 0, 0,  0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 60, 100);
        apply("off60",   0, 1, 0, 60,  40, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, -1, 0,  0);
        apply("off60b",  0, 1, 0, 60,  40, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, -1, 0,  0);
        apply("end0",    0, 0, 0,  0,   0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 60, 100);
        // fill all voices, then steal the oldest
        apply("fill60",  0, 1, 1, 60,  10, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 60, 10);
        apply("fill62",  0, 1, 1, 62,  20, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 1, 62, 20);
        apply("fill64",  0, 1, 1, 64,  30, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0111, 2, 64, 30);
        apply("fill67",  0, 1, 1, 67,  40, 0, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 3, 67, 40);
        apply("steal72", 0, 1, 1, 72,  50, 0, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 0, 72, 50);
        // velocity-0 note-on acts as note-off
        apply("v0off64", 0, 1, 1, 64,   0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 2, 64, 30);
        // releasing voice is preferred over stealing a held one
        apply("on80rel", 0, 1, 1, 80,  60, 0, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 2, 80, 60);
        apply("endheld", 0, 0, 0,  0,   0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b1111, 1, 62, 20);
        apply("off72",   0, 1, 0, 72,   0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b1111, -1, 0,  0);
        apply("off62",   0, 1, 0, 62,   0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b1111, -1, 0,  0);
        apply("off67",   0, 1, 0, 67,   0, 0, 4'b0000, 4'b0000, 4'b1000, 4'b1111, -1, 0,  0);
        apply("off80",   0, 1, 0, 80,   0, 0, 4'b0000, 4'b0000, 4'b0100, 4'b1111, -1, 0,  0);
        apply("endall",  0, 0, 0,  0,   0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, -1, 0,  0);
        // sustain pedal
        apply("peddn",   0, 0, 0,  0,   0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, 0,  0);
        apply("pon60",   0, 1, 1, 60,  70, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 60, 70);
        apply("poff60",  0, 1, 0, 60,   0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, -1, 0,  0);
        apply("psus",    0, 0, 0,  0,   0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, -1, 0,  0);
        apply("pedup",   0, 0, 0,  0,   0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, -1, 0,  0);
        apply("pidle",   0, 0, 0,  0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, -1, 0,  0);
        // retrigger of a releasing voice racing its envelope end
        apply("retrig",  0, 1, 1, 60,  90, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 60, 90);
        apply("rtkeep",  0, 0, 0,  0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 60, 90);
        // pedal release and pedal-up note-off in the same cycle
        apply("peddn2",  0, 0, 0,  0,   0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, -1, 0,  0);
        apply("pon62",   0, 1, 1, 62,  15, 1, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 1, 62, 15);
        apply("poff62",  0, 1, 0, 62,   0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0011, -1, 0,  0);
        apply("pupoff",  0, 1, 0, 60,   0, 0, 4'b0000, 4'b0000, 4'b0011, 4'b0011, -1, 0,  0);
        // reset mid-operation discards everything
        apply("midrst",  1, 1, 1, 64,  33, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1,  0,  0);
        apply("postrst", 0, 1, 1, 64,  33, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,  0,  0);
        apply("firston", 0, 1, 1, 64,  33, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 64, 33);

        @(negedge clk);
        event_valid  = 1'b0;
        envelope_end = '0;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
